// File: rtl/inv_key_schedule.sv
// AES-128 key schedule for a decryptor: expands the cipher key forward to round 10,
// then steps back one round key per request using the inverse recurrence.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[a_i];
endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         req_key,
  input  logic         rewind,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] last_q, last_d;
  logic [3:0]   idx_q, idx_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w1, inv_w2, inv_w3;
  logic [31:0] sub_in, rot_w, sub_w, rcon_w;
  logic [31:0] fwd0, fwd1, fwd2, fwd3, inv_w0;
  logic [3:0]  rcon_idx;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign inv_w3 = w3 ^ w2;
  assign inv_w2 = w2 ^ w1;
  assign inv_w1 = w1 ^ w0;

  // Forward and inverse steps never run in the same cycle, so they share one SubWord.
  assign sub_in   = (state_q == EXPAND) ? w3 : inv_w3;
  assign rot_w    = {sub_in[23:0], sub_in[31:24]};
  assign rcon_idx = (state_q == EXPAND) ? 4'(idx_q + 4'd1) : idx_q;
  assign rcon_w   = {rcon(rcon_idx), 24'h000000};

  aes_sbox u_sbox0 (.a_i(rot_w[31:24]), .s_o(sub_w[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_w[23:16]), .s_o(sub_w[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_w[15:8]),  .s_o(sub_w[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_w[7:0]),   .s_o(sub_w[7:0]));

  assign fwd0   = w0 ^ sub_w ^ rcon_w;
  assign fwd1   = w1 ^ fwd0;
  assign fwd2   = w2 ^ fwd1;
  assign fwd3   = w3 ^ fwd2;
  assign inv_w0 = w0 ^ sub_w ^ rcon_w;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    if (key_load) begin
      state_d = EXPAND;
      key_d   = key_in;
      last_d  = '0;
      idx_d   = 4'd0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        EXPAND: begin
          key_d = {fwd0, fwd1, fwd2, fwd3};
          idx_d = 4'(idx_q + 4'd1);
          if (idx_q == 4'd9) begin
            last_d  = {fwd0, fwd1, fwd2, fwd3};
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = READY;
          end
        end
        READY: begin
          if (rewind) begin
            key_d = last_q;
            idx_d = 4'd10;
          end else if (req_key && (idx_q != 4'd0)) begin
            key_d = {inv_w0, inv_w1, inv_w2, inv_w3};
            idx_d = 4'(idx_q - 4'd1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      last_q  <= '0;
      idx_q   <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign key_ready = ready_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule; expected outputs come from the published
// AES-128 round-key tables and are queued per step, then popped after the edge.

module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         req_key;
  logic         rewind;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_ready;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic [127:0] key;
    logic         rdy;
    logic         bsy;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  localparam logic [127:0] K1_RK [11] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  localparam logic [127:0] K2_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  inv_key_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .req_key   (req_key),
    .rewind    (rewind),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_ready (key_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".idx"}, 128'(round_idx), 128'(e.idx));
    chk({e.tag, ".key"}, round_key, e.key);
    chk({e.tag, ".ready"}, 128'(key_ready), 128'(e.rdy));
    chk({e.tag, ".busy"}, 128'(busy), 128'(e.bsy));
  endtask

  // Drive one edge's inputs, queue what the outputs must be after it, then compare.
  task automatic step(input logic ld, input logic rq, input logic rw, input logic [127:0] k,
                      input string tag, input logic [3:0] idx, input logic [127:0] key,
                      input logic rdy, input logic bsy);
    exp_t e;
    key_load = ld;
    req_key  = rq;
    rewind   = rw;
    key_in   = k;
    e.tag = tag; e.idx = idx; e.key = key; e.rdy = rdy; e.bsy = bsy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
    key_load = 1'b0;
  endtask

  task automatic expand_steps(input string tag, input logic [127:0] rk [11],
                              input logic rq, input logic rw);
    for (int i = 1; i <= 10; i++)
      step(1'b0, rq, rw, '0, $sformatf("%s_exp%0d", tag, i), 4'(i), rk[i], i == 10, i < 10);
  endtask

  task automatic wait_ready(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!key_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (!key_ready) chk($sformatf("%s_busy%0d", tag, n), 128'(busy), 128'(1));
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_edges));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".key"}, round_key, '0);
    chk({tag, ".idx"}, 128'(round_idx), '0);
    chk({tag, ".ready"}, 128'(key_ready), '0);
    chk({tag, ".busy"}, 128'(busy), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    req_key  = 1'b0;
    rewind   = 1'b0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    step(1'b0, 1'b1, 1'b1, '0, "idle_ignore", 4'd0, '0, 1'b0, 1'b0);

    // Key 1: full forward expansion, then step all the way down.
    step(1'b1, 1'b0, 1'b0, K1, "k1_load", 4'd0, K1, 1'b0, 1'b1);
    expand_steps("k1", K1_RK, 1'b0, 1'b0);
    for (int i = 9; i >= 0; i--)
      step(1'b0, 1'b1, 1'b0, '0, $sformatf("k1_dn%0d", i), 4'(i), K1_RK[i], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, "k1_sat", 4'd0, K1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0, "k1_rewind", 4'd10, K1_RK[10], 1'b1, 1'b0);

    // Key 2: requests and rewinds held during expansion must be ignored.
    step(1'b1, 1'b0, 1'b0, K2, "k2_load", 4'd0, K2, 1'b0, 1'b1);
    expand_steps("k2", K2_RK, 1'b1, 1'b1);
    for (int i = 9; i >= 0; i--)
      step(1'b0, 1'b1, 1'b0, '0, $sformatf("k2_dn%0d", i), 4'(i), K2_RK[i], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, "k2_sat", 4'd0, K2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0, "k2_rewind", 4'd10, K2_RK[10], 1'b1, 1'b0);
    for (int i = 9; i >= 4; i--)
      step(1'b0, 1'b1, 1'b0, '0, $sformatf("k2_r%0d", i), 4'(i), K2_RK[i], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, '0, "rewind_over_req", 4'd10, K2_RK[10], 1'b1, 1'b0);

    // Restart expansion mid-way with a different key.
    step(1'b1, 1'b0, 1'b0, K1, "rs_load", 4'd0, K1, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b0, 1'b0, '0, $sformatf("rs_exp%0d", i), 4'(i), K1_RK[i], 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, K2, "rs_reload", 4'd0, K2, 1'b0, 1'b1);
    wait_ready("rs", 10);
    chk("rs_final.key", round_key, K2_RK[10]);
    chk("rs_final.idx", 128'(round_idx), 128'(10));

    // key_load outranks rewind and req_key in READY.
    step(1'b1, 1'b1, 1'b1, K1, "prio_load", 4'd0, K1, 1'b0, 1'b1);
    expand_steps("prio", K1_RK, 1'b0, 1'b0);
    for (int i = 9; i >= 7; i--)
      step(1'b0, 1'b1, 1'b0, '0, $sformatf("pr_dn%0d", i), 4'(i), K1_RK[i], 1'b1, 1'b0);

    // Asynchronous reset in READY at round 7.
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("rst_ready");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, '0, "rst_req", 4'd0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0, "rst_rewind", 4'd0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, K2, "rst_load", 4'd0, K2, 1'b0, 1'b1);
    wait_ready("rst", 10);
    chk("rst_final.key", round_key, K2_RK[10]);
    step(1'b0, 1'b1, 1'b0, '0, "rst_dn9", 4'd9, K2_RK[9], 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
